count_bcd_display: RTL and testbench

- Downstream consumer of the 8-bit up/down counter output.
- Converts the unsigned count to 3-digit BCD with a sequential shift-add-3 (double-dabble) FSM.
- Drives a time-multiplexed 3-digit common-anode seven-segment display.
- Sits between the counter and the board display pins.

---
 rtl/count_bcd_display.sv | 173 +++++++++++++++++
 tb/tb_count_bcd_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_bcd_display: 8-bit count -> 3-digit BCD (shift-add-3 FSM) driving a   |
// | multiplexed common-anode 7-seg display. Option macro: LEADING_ZERO_BLANK_EN |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module count_bcd_display #(
  parameter int REFRESH_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] C_REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      last_val_q, last_val_d;
  logic [7:0]      sample_q, sample_d;
  logic [11:0]     scratch_q, scratch_d;
  logic [2:0]      iter_q, iter_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [1:0]      digit_idx_q, digit_idx_d;

  logic [11:0]     adj;
  logic [3:0]      nibble;
  logic [6:0]      seg_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    last_val_d    = last_val_q;
    sample_d      = sample_q;
    scratch_d     = scratch_q;
    iter_d        = iter_q;
    bcd_d         = bcd_q;
    bcd_valid_d   = 1'b0;
    busy_d        = busy_q;
    refresh_cnt_d = refresh_cnt_q;
    digit_idx_d   = digit_idx_q;

    // Add-3 correction applied before each shift
    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (count_in != last_val_q) begin
          sample_d   = count_in;
          last_val_d = count_in;
          scratch_d  = 12'h000;
          iter_d     = 3'd0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        busy_d                = 1'b1;
        {scratch_d, sample_d} = {adj[10:0], sample_q, 1'b0};
        iter_d                = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d      = 1'b1;
        bcd_d       = scratch_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (refresh_cnt_q == C_REFRESH_LAST) begin
      refresh_cnt_d = '0;
      digit_idx_d   = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_val_q    <= 8'h00;
      sample_q      <= 8'h00;
      scratch_q     <= 12'h000;
      iter_q        <= 3'd0;
      bcd_q         <= 12'h000;
      bcd_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      last_val_q    <= last_val_d;
      sample_q      <= sample_d;
      scratch_q     <= scratch_d;
      iter_q        <= iter_d;
      bcd_q         <= bcd_d;
      bcd_valid_q   <= bcd_valid_d;
      busy_q        <= busy_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  always_comb begin
    case (digit_idx_q)
      2'd0:    nibble = bcd_q[3:0];
      2'd1:    nibble = bcd_q[7:4];
      2'd2:    nibble = bcd_q[11:8];
      default: nibble = 4'hf;
    endcase
    seg_raw = seg_decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
    seg = seg_raw;
    if ((digit_idx_q == 2'd2) && (bcd_q[11:8] == 4'd0)) begin
      seg = 7'b1111111;
    end
    if ((digit_idx_q == 2'd1) && (bcd_q[11:4] == 8'h00)) begin
      seg = 7'b1111111;
    end
`else
    seg = seg_raw;
`endif
  end

  assign an        = ~(3'b001 << digit_idx_q);
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_count_bcd_display: scoreboard bench for count_bcd_display               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_count_bcd_display;

  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count_in;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [2:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_edge = 0;

  typedef struct {
    logic [11:0] val;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  count_bcd_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every bcd_valid pulse must match the oldest expectation, value and cycle
  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {20'h0, bcd}, 32'hffff_ffff);
      end else begin
        mon_e = sb.pop_front();
        check("bcd_value", {20'h0, bcd}, {20'h0, mon_e.val});
        check("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic expect_result(input logic [11:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    int k;
    int d;
    logic [6:0] es;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      k = cyc - rst_edge;
      d = (k / REFRESH_DIV) % 3;
      es = (d == 0) ? s0 : ((d == 1) ? s1 : s2);
      check("scan_an", {29'h0, an}, {29'h0, ~(3'b001 << d)});
      check("scan_seg", {25'h0, seg}, {25'h0, es});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst      = 1'b1;
    count_in = 8'd0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    rst_edge = cyc;

    // Reset state
    check("rst_bcd", {20'h0, bcd}, 32'h000);
    check("rst_valid", {31'h0, bcd_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_an", {29'h0, an}, 32'b110);
    check("rst_seg", {25'h0, seg}, 32'b1000000);
    repeat (3) @(negedge clk);
    check("idle_no_start", {31'h0, busy}, 32'd0);

    // 123: busy/valid timing cycle by cycle
    count_in = 8'd123;
    n = cyc + 1;
    expect_result(12'h123, n + 9);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check("busy_timing", {31'h0, busy}, (k <= 9) ? 32'd1 : 32'd0);
      check("valid_timing", {31'h0, bcd_valid}, (k == 9) ? 32'd1 : 32'd0);
    end

    // 255 then 0
    count_in = 8'd255;
    expect_result(12'h255, cyc + 10);
    wait_idle(20);
    count_in = 8'd0;
    expect_result(12'h000, cyc + 10);
    wait_idle(20);

    // 10, 11, 12 on consecutive cycles: 11 is never converted
    count_in = 8'd10;
    n = cyc + 1;
    expect_result(12'h010, n + 9);
    @(negedge clk);
    count_in = 8'd11;
    @(negedge clk);
    count_in = 8'd12;
    expect_result(12'h012, n + 19);
    wait_idle(40);
    check("final_12", {20'h0, bcd}, 32'h012);

    // Scan with 207
    count_in = 8'd207;
    expect_result(12'h207, cyc + 10);
    wait_idle(20);
    scan_check(7'b1111000, 7'b1000000, 7'b0100100);

    // Scan with 007 (leading zeros)
    count_in = 8'd7;
    expect_result(12'h007, cyc + 10);
    wait_idle(20);
`ifdef LEADING_ZERO_BLANK_EN
    scan_check(7'b1111000, 7'b1111111, 7'b1111111);
`else
    scan_check(7'b1111000, 7'b1000000, 7'b1000000);
`endif

    // Reset 4 cycles into a conversion of 200
    count_in = 8'd200;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_bcd", {20'h0, bcd}, 32'h000);
    check("abort_valid", {31'h0, bcd_valid}, 32'd0);
    rst      = 1'b0;
    rst_edge = cyc;
    expect_result(12'h200, cyc + 10);
    wait_idle(30);
    check("after_abort_bcd", {20'h0, bcd}, 32'h200);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
